// File: rtl/layer_scheduler_if.sv
// Handshake bundle between the layer-chain sequencer and the layers/calc unit it drives.
// master = the scheduler, slave = the layer chain and control logic around it.
interface layer_scheduler_if #(
    parameter int NUM_LAYERS = 4,
    parameter int CALC_W     = 816
);
    logic                         start_i;
    logic                         abort_i;
    logic [NUM_LAYERS-1:0]        layer_done_i;
    logic [NUM_LAYERS*CALC_W-1:0] layer_calc_i;
    logic [NUM_LAYERS-1:0]        layer_en_o;
    logic [CALC_W-1:0]            calc_data_o;
    logic                         buf_sel_o;
    logic [7:0]                   layer_idx_o;
    logic                         busy_o;
    logic                         done_o;
    logic                         err_o;

    modport master (
        input  start_i, abort_i, layer_done_i, layer_calc_i,
        output layer_en_o, calc_data_o, buf_sel_o, layer_idx_o, busy_o, done_o, err_o
    );

    modport slave (
        output start_i, abort_i, layer_done_i, layer_calc_i,
        input  layer_en_o, calc_data_o, buf_sel_o, layer_idx_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/layer_scheduler.sv
// Sequences the CNN layer chain: enables one layer at a time, muxes its calc bundle onto the
// shared calc unit, flips the ping-pong buffers between layers and flags layers that hang.
module layer_scheduler #(
    parameter int NUM_LAYERS   = 4,
    parameter int CALC_W       = 816,
    parameter int DRAIN_CYCLES = 7,
    parameter int TIMEOUT      = 65535
) (
    input  logic              clk,
    input  logic              rst,
    layer_scheduler_if.master bus
);
    localparam int IDX_W   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int GAP_LEN = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES : 1;
    localparam int GAP_W   = $clog2(GAP_LEN + 1);

    localparam logic [GAP_W-1:0]      GAP_LAST = GAP_W'(GAP_LEN - 1);
    localparam logic [31:0]           CYC_LAST = 32'(TIMEOUT) - 32'd1;
    localparam logic [7:0]            LAST_IDX = 8'(NUM_LAYERS - 1);
    localparam logic [NUM_LAYERS-1:0] EN_FIRST = NUM_LAYERS'(1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_DONE, S_ERROR} state_t;

    state_t                state_reg;
    logic [NUM_LAYERS-1:0] layer_en_reg;
    logic [CALC_W-1:0]     calc_data_reg;
    logic                  buf_sel_reg;
    logic [7:0]            layer_idx_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  err_reg;
    logic [31:0]           cycle_cnt_reg;
    logic [GAP_W-1:0]      gap_cnt_reg;

    logic [CALC_W-1:0]     calc_slice [NUM_LAYERS];
    logic [IDX_W-1:0]      cur_idx;
    logic                  cur_done;
    logic [CALC_W-1:0]     cur_calc;
    logic                  timeout_hit;

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_slice
            assign calc_slice[gi] = bus.layer_calc_i[gi*CALC_W +: CALC_W];
        end
    endgenerate

    // Only the active layer's done and bundle are ever looked at.
    assign cur_idx     = layer_idx_reg[IDX_W-1:0];
    assign cur_done    = bus.layer_done_i[cur_idx];
    assign cur_calc    = calc_slice[cur_idx];
    assign timeout_hit = (TIMEOUT != 0) && (cycle_cnt_reg == CYC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            layer_en_reg  <= '0;
            calc_data_reg <= '0;
            buf_sel_reg   <= 1'b0;
            layer_idx_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            cycle_cnt_reg <= '0;
            gap_cnt_reg   <= '0;
        end else begin
            done_reg      <= 1'b0;
            calc_data_reg <= '0;
            if (bus.abort_i) begin
                state_reg    <= S_IDLE;
                layer_en_reg <= '0;
                busy_reg     <= 1'b0;
                buf_sel_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (bus.start_i) begin
                            state_reg     <= S_RUN;
                            layer_idx_reg <= '0;
                            buf_sel_reg   <= 1'b0;
                            err_reg       <= 1'b0;
                            cycle_cnt_reg <= '0;
                            layer_en_reg  <= EN_FIRST;
                            busy_reg      <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (cycle_cnt_reg != '1) begin
                            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
                        end
                        if (cur_done) begin
                            state_reg     <= S_GAP;
                            layer_en_reg  <= '0;
                            gap_cnt_reg   <= '0;
                            calc_data_reg <= cur_calc;
                        end else if (timeout_hit) begin
                            state_reg    <= S_ERROR;
                            layer_en_reg <= '0;
                            busy_reg     <= 1'b0;
                            err_reg      <= 1'b1;
                        end else begin
                            calc_data_reg <= cur_calc;
                        end
                    end
                    S_GAP: begin
                        // Drain window lets the shared calc pipeline empty before the next layer.
                        if (gap_cnt_reg == GAP_LAST) begin
                            if (layer_idx_reg == LAST_IDX) begin
                                state_reg <= S_DONE;
                                done_reg  <= 1'b1;
                                busy_reg  <= 1'b0;
                            end else begin
                                state_reg     <= S_RUN;
                                layer_idx_reg <= layer_idx_reg + 8'd1;
                                buf_sel_reg   <= ~buf_sel_reg;
                                cycle_cnt_reg <= '0;
                                layer_en_reg  <= EN_FIRST << (layer_idx_reg + 8'd1);
                                calc_data_reg <= cur_calc;
                            end
                        end else begin
                            gap_cnt_reg   <= gap_cnt_reg + GAP_W'(1);
                            calc_data_reg <= cur_calc;
                        end
                    end
                    S_DONE:  state_reg <= S_IDLE;
                    S_ERROR: state_reg <= S_IDLE;
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.layer_en_o  = layer_en_reg;
    assign bus.calc_data_o = calc_data_reg;
    assign bus.buf_sel_o   = buf_sel_reg;
    assign bus.layer_idx_o = layer_idx_reg;
    assign bus.busy_o      = busy_reg;
    assign bus.done_o      = done_reg;
    assign bus.err_o       = err_reg;
endmodule

// File: tb/tb_layer_scheduler.sv
// Randomized bench for layer_scheduler: a phase/counter model of the chain is compared with the
// DUT every cycle, and directed scenarios pin the model with hand-computed numbers.
module tb_layer_scheduler;
    localparam int NL = 4;
    localparam int CW = 816;
    localparam int DR = 7;
    localparam int TO = 50;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    layer_scheduler_if #(.NUM_LAYERS(NL), .CALC_W(CW)) bus ();

    layer_scheduler #(.NUM_LAYERS(NL), .CALC_W(CW), .DRAIN_CYCLES(DR), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus controls, written only by the main sequence
    int delay [NL];
    int hang_layer  = -1;
    bit pulse_mode  = 1'b0;
    bit spur_en     = 1'b0;
    bit calc_rand   = 1'b0;
    int abort_layer = -1;
    int abort_pct   = 0;
    int start_pct   = 0;
    int start_req   = 0;
    int mon_clr_req = 0;
    bit chk_en      = 1'b0;

    task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h (low 128 bits)", name, cyc,
                     got[127:0], exp[127:0]);
        end
    endtask

    // Layer-chain environment: layers answer their enable after delay[k] cycles.
    initial begin
        logic [NL*CW+31:0] rnd;
        logic [NL-1:0]     dn;
        logic [NL-1:0]     en;
        int                age [NL];
        int                start_ack;
        start_ack        = 0;
        bus.start_i      = 1'b0;
        bus.abort_i      = 1'b0;
        bus.layer_done_i = '0;
        bus.layer_calc_i = '0;
        rnd              = '0;
        for (int k = 0; k < NL; k++) age[k] = 0;
        forever begin
            @(posedge clk);
            #2;
            en = bus.layer_en_o;
            dn = '0;
            for (int k = 0; k < NL; k++) begin
                age[k] = en[k] ? age[k] + 1 : 0;
                if (en[k] && k != hang_layer &&
                    (pulse_mode ? (age[k] == delay[k]) : (age[k] >= delay[k])))
                    dn[k] = 1'b1;
            end
            if (spur_en) begin
                dn = dn | (NL'($urandom()) & ~en);
                if (en[1]) dn[3] = 1'b1;
            end
            bus.layer_done_i = dn;
            bus.abort_i = (abort_layer >= 0 && dn[abort_layer]) ||
                          (int'($urandom_range(999)) < abort_pct);
            bus.start_i = (start_req != start_ack) || (int'($urandom_range(99)) < start_pct);
            start_ack   = start_req;
            if (calc_rand) begin
                for (int w = 0; w < (NL*CW+31)/32; w++) rnd[w*32 +: 32] = $urandom();
                bus.layer_calc_i = rnd[NL*CW-1:0];
            end else begin
                for (int k = 0; k < NL; k++) bus.layer_calc_i[k*CW +: CW] = CW'(k + 'hA0);
            end
        end
    end

    // Behavioural model: which layer owns the chain, how long it has run, how much gap is left.
    bit            m_busy = 0, m_gap = 0, m_term = 0, m_done = 0, m_err = 0, m_buf = 0;
    int            m_k = 0, m_run = 0, m_gapn = 0;
    logic [CW-1:0] m_calc = '0;

    task automatic model_step();
        logic [CW-1:0] sel;
        sel    = bus.layer_calc_i[m_k*CW +: CW];
        m_done = 1'b0;
        m_calc = '0;
        if (bus.abort_i) begin
            m_busy = 0; m_gap = 0; m_term = 0; m_buf = 0;
            return;
        end
        if (m_term) begin
            m_term = 0;
            return;
        end
        if (!m_busy) begin
            if (bus.start_i) begin
                m_busy = 1; m_gap = 0; m_k = 0; m_buf = 0; m_err = 0; m_run = 0;
            end
            return;
        end
        if (!m_gap) begin
            m_run++;
            if (bus.layer_done_i[m_k]) begin
                m_gap = 1; m_gapn = 0; m_calc = sel;
            end else if (m_run == TO) begin
                m_busy = 0; m_term = 1; m_err = 1;
            end else begin
                m_calc = sel;
            end
        end else begin
            m_gapn++;
            if (m_gapn == ((DR > 0) ? DR : 1)) begin
                if (m_k == NL - 1) begin
                    m_busy = 0; m_term = 1; m_done = 1;
                end else begin
                    m_calc = sel;
                    m_k++;
                    m_buf = m_k[0];
                    m_gap = 0; m_run = 0;
                end
            end else begin
                m_calc = sel;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy = 0; m_gap = 0; m_term = 0; m_done = 0; m_err = 0; m_buf = 0;
                m_k = 0; m_run = 0; m_gapn = 0; m_calc = '0;
            end else begin
                model_step();
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        logic [NL-1:0] exp_en;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_en = (m_busy && !m_gap) ? (NL'(1) << m_k) : '0;
                chk("layer_en", CW'(bus.layer_en_o), CW'(exp_en));
                chk("busy", CW'(bus.busy_o), CW'(m_busy));
                chk("done", CW'(bus.done_o), CW'(m_done));
                chk("err", CW'(bus.err_o), CW'(m_err));
                chk("buf_sel", CW'(bus.buf_sel_o), CW'(m_buf));
                chk("layer_idx", CW'(bus.layer_idx_o), CW'(m_k));
                chk("calc_data", bus.calc_data_o, m_calc);
            end
        end
    end

    // Monitor for the directed literal checks
    int            en_cnt [NL];
    bit            buf_rise [NL];
    logic [CW-1:0] calc_rise [NL];
    int            gap_cyc, done_cnt;
    initial begin
        logic [NL-1:0] prev_en;
        bit            pend [NL];
        int            clr_ack;
        clr_ack = 0; prev_en = '0; gap_cyc = 0; done_cnt = 0;
        for (int k = 0; k < NL; k++) begin
            en_cnt[k] = 0; buf_rise[k] = 0; calc_rise[k] = '0; pend[k] = 0;
        end
        forever begin
            @(negedge clk);
            if (clr_ack != mon_clr_req) begin
                clr_ack = mon_clr_req; gap_cyc = 0; done_cnt = 0;
                for (int k = 0; k < NL; k++) begin
                    en_cnt[k] = 0; buf_rise[k] = 1'b1; calc_rise[k] = '1; pend[k] = 0;
                end
            end
            for (int k = 0; k < NL; k++) begin
                if (bus.layer_en_o[k]) en_cnt[k]++;
                if (bus.layer_en_o[k] && !prev_en[k]) begin
                    buf_rise[k] = bus.buf_sel_o;
                    pend[k] = 1;
                end else if (pend[k]) begin
                    calc_rise[k] = bus.calc_data_o;
                    pend[k] = 0;
                end
            end
            if (bus.busy_o && bus.layer_en_o == '0) gap_cyc++;
            if (bus.done_o) done_cnt++;
            prev_en = bus.layer_en_o;
        end
    end

    task automatic pulse_start();
        start_req++;
        @(posedge clk);
        @(posedge clk);
        #3;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (bus.busy_o && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.busy_o) begin
            errors++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", limit);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        start_pct = 0;
        abort_pct = 0;
        repeat (3) @(negedge clk);
        wait_idle(3000);
    endtask

    task automatic clear_mon();
        mon_clr_req++;
        @(negedge clk);
    endtask

    task automatic check_nominal(input string tag);
        for (int k = 0; k < NL; k++) begin
            chk({tag, "_en_len"}, CW'(en_cnt[k]), CW'(20));
            chk({tag, "_buf_at_rise"}, CW'(buf_rise[k]), CW'(k % 2));
            chk({tag, "_calc_after_rise"}, calc_rise[k], CW'(k + 'hA0));
        end
        chk({tag, "_gap_cycles"}, CW'(gap_cyc), CW'(28));
        chk({tag, "_done_pulses"}, CW'(done_cnt), CW'(1));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NL; k++) delay[k] = 20;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("reset_en", CW'(bus.layer_en_o), CW'(0));
        chk("reset_busy", CW'(bus.busy_o), CW'(0));
        chk("reset_err", CW'(bus.err_o), CW'(0));
        chk("reset_idx", CW'(bus.layer_idx_o), CW'(0));
        chk("reset_calc", bus.calc_data_o, CW'(0));
        chk_en = 1'b1;

        // Nominal chain with fixed bundles k+0xA0
        clear_mon();
        pulse_start();
        wait_idle(1000);
        check_nominal("nominal");

        // Spurious done on layer 3 during layer 1, repeated start requests mid-run
        spur_en = 1'b1;
        start_pct = 5;
        clear_mon();
        pulse_start();
        wait_idle(1000);
        spur_en = 1'b0;
        start_pct = 0;
        check_nominal("spurious");
        settle();

        // Layer 2 hangs: timeout after exactly TO enabled cycles
        hang_layer = 2;
        clear_mon();
        pulse_start();
        wait_idle(1000);
        chk("timeout_en2_len", CW'(en_cnt[2]), CW'(TO));
        chk("timeout_err", CW'(bus.err_o), CW'(1));
        chk("timeout_busy", CW'(bus.busy_o), CW'(0));
        chk("timeout_done", CW'(done_cnt), CW'(0));
        hang_layer = -1;
        clear_mon();
        pulse_start();
        chk("restart_clears_err", CW'(bus.err_o), CW'(0));
        wait_idle(1000);
        chk("restart_done", CW'(done_cnt), CW'(1));

        // Abort coincides with layer 1's done
        delay[1] = 5;
        abort_layer = 1;
        clear_mon();
        pulse_start();
        wait_idle(1000);
        chk("abort_en1_len", CW'(en_cnt[1]), CW'(5));
        chk("abort_en2_len", CW'(en_cnt[2]), CW'(0));
        chk("abort_gap", CW'(gap_cyc), CW'(DR));
        chk("abort_done", CW'(done_cnt), CW'(0));
        chk("abort_en_now", CW'(bus.layer_en_o), CW'(0));
        abort_layer = -1;
        delay[1] = 20;

        // Async reset in the middle of a drain gap
        clear_mon();
        pulse_start();
        begin
            int n;
            n = 0;
            while (!(bus.busy_o && bus.layer_en_o == '0) && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("reach_gap", CW'(bus.busy_o), CW'(1));
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_busy", CW'(bus.busy_o), CW'(0));
        chk("async_rst_en", CW'(bus.layer_en_o), CW'(0));
        chk("async_rst_idx", CW'(bus.layer_idx_o), CW'(0));
        chk("async_rst_calc", bus.calc_data_o, CW'(0));
        rst = 1'b0;
        clear_mon();
        pulse_start();
        wait_idle(1000);
        check_nominal("after_rst");

        // Randomized runs: delays, pulse/level done, spurious dones, stray starts and aborts
        calc_rand = 1'b1;
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < NL; k++)
                delay[k] = ($urandom_range(9) == 0) ? int'($urandom_range(60, 45))
                                                     : int'($urandom_range(30, 1));
            pulse_mode = 1'($urandom_range(1));
            spur_en    = 1'($urandom_range(1));
            start_pct  = ($urandom_range(1) == 1) ? 5 : 0;
            abort_pct  = ($urandom_range(3) == 0) ? 8 : 0;
            hang_layer = ($urandom_range(7) == 0) ? int'($urandom_range(NL - 1)) : -1;
            pulse_start();
            wait_idle(3000);
            settle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
